// File: rtl/shared_ram_arbiter.sv
// Round-robin arbiter that time-shares one single-port 256x8 RAM among NUM_REQ requesters.
// One command is latched per grant; RAM strobes, ack and read data all come from registers.
module shared_ram_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 8,
    parameter int IDX_W   = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_i,
    input  logic [NUM_REQ-1:0]        we_i,
    input  logic [NUM_REQ*ADDR_W-1:0] addr_i,
    input  logic [NUM_REQ*DATA_W-1:0] wdata_i,
    output logic [NUM_REQ-1:0]        ack_o,
    output logic [DATA_W-1:0]         rdata_o,
    output logic [IDX_W-1:0]          grant_id_o,
    output logic                      busy_o,
    output logic                      mem_enable_o,
    output logic                      mem_write_o,
    output logic                      mem_read_o,
    output logic [ADDR_W-1:0]         mem_address_o,
    output logic [DATA_W-1:0]         mem_data_in_o,
    input  logic [DATA_W-1:0]         mem_data_out_i
);

    typedef enum logic [1:0] {IDLE, ISSUE, RDATA, DONE} state_t;

    state_t              state_q;
    logic [IDX_W-1:0]    lastGnt_q;
    logic [IDX_W-1:0]    idx_q;
    logic                we_q;
    logic [NUM_REQ-1:0]  ack_q;
    logic [DATA_W-1:0]   rdata_q;
    logic                memEnable_q;
    logic                memWrite_q;
    logic                memRead_q;
    logic [ADDR_W-1:0]   memAddress_q;
    logic [DATA_W-1:0]   memDataIn_q;

    logic                winFound_d;
    logic [IDX_W-1:0]    winIdx_d;
    logic                winWe_d;
    logic [ADDR_W-1:0]   winAddr_d;
    logic [DATA_W-1:0]   winData_d;
    logic [NUM_REQ-1:0]  ackOneHot_d;
    logic [IDX_W:0]      candSum;
    logic [IDX_W-1:0]    cand;

    // Scan starts just after the last grant, so the previous winner is always checked last.
    always_comb begin
        winFound_d = 1'b0;
        winIdx_d   = '0;
        candSum    = '0;
        cand       = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            candSum = {1'b0, lastGnt_q} + (IDX_W+1)'(k);
            if (candSum >= (IDX_W+1)'(NUM_REQ)) begin
                candSum = candSum - (IDX_W+1)'(NUM_REQ);
            end
            cand = candSum[IDX_W-1:0];
            if (!winFound_d && req_i[cand]) begin
                winFound_d = 1'b1;
                winIdx_d   = cand;
            end
        end
    end

    always_comb begin
        winWe_d     = 1'b0;
        winAddr_d   = '0;
        winData_d   = '0;
        ackOneHot_d = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (winIdx_d == IDX_W'(i)) begin
                winWe_d   = we_i[i];
                winAddr_d = addr_i[i*ADDR_W +: ADDR_W];
                winData_d = wdata_i[i*DATA_W +: DATA_W];
            end
            ackOneHot_d[i] = (idx_q == IDX_W'(i));
        end
    end

    // RAM strobes are loaded on the grant edge so they are live for exactly the ISSUE cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            lastGnt_q    <= IDX_W'(NUM_REQ - 1);
            idx_q        <= '0;
            we_q         <= 1'b0;
            ack_q        <= '0;
            rdata_q      <= '0;
            memEnable_q  <= 1'b0;
            memWrite_q   <= 1'b0;
            memRead_q    <= 1'b0;
            memAddress_q <= '0;
            memDataIn_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (winFound_d) begin
                        idx_q        <= winIdx_d;
                        lastGnt_q    <= winIdx_d;
                        we_q         <= winWe_d;
                        memEnable_q  <= 1'b1;
                        memWrite_q   <= winWe_d;
                        memRead_q    <= ~winWe_d;
                        memAddress_q <= winAddr_d;
                        memDataIn_q  <= winData_d;
                        state_q      <= ISSUE;
                    end
                end
                ISSUE: begin
                    memEnable_q  <= 1'b0;
                    memWrite_q   <= 1'b0;
                    memRead_q    <= 1'b0;
                    memAddress_q <= '0;
                    memDataIn_q  <= '0;
                    if (we_q) begin
                        ack_q   <= ackOneHot_d;
                        state_q <= DONE;
                    end else begin
                        state_q <= RDATA;
                    end
                end
                RDATA: begin
                    rdata_q <= mem_data_out_i;
                    ack_q   <= ackOneHot_d;
                    state_q <= DONE;
                end
                DONE: begin
                    ack_q   <= '0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ack_o         = ack_q;
    assign rdata_o       = rdata_q;
    assign grant_id_o    = idx_q;
    assign busy_o        = (state_q != IDLE);
    assign mem_enable_o  = memEnable_q;
    assign mem_write_o   = memWrite_q;
    assign mem_read_o    = memRead_q;
    assign mem_address_o = memAddress_q;
    assign mem_data_in_o = memDataIn_q;

endmodule
